// File: rtl/dispatch_ctrl.sv
// In-order dispatch controller: 2-entry skid buffer steering renamed entries to the ALU or LS issue queue.
// Optional macro DISPATCH_BYPASS_EN lets an arriving entry dispatch in its arrival cycle when the buffer is empty.
module dispatch_ctrl #(
  parameter int ENTRY_SIZE = 192,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FREEZE,
  input  logic                  mispredict,
  input  logic                  flush_fCOM,
  input  logic                  in_valid,
  input  logic [ENTRY_SIZE-1:0] in_entry,
  output logic                  in_ready,
  input  logic                  full_alu,
  input  logic                  full_ls,
  output logic                  do_write_alu,
  output logic                  do_write_ls,
  output logic [ENTRY_SIZE-1:0] write_data,
  output logic                  do_clear_2BB,
  output logic [5:0]            clear_index_2BB,
  output logic [31:0]           dispatch_count
);

  localparam int DEST_HI = 179;
  localparam int DEST_LO = 174;
  localparam int WB_BIT  = 140;
  localparam int LD_BIT  = 133;
  localparam int ST_BIT  = 135;
  localparam logic [ENTRY_SIZE-1:0] FORCE_MASK = {1'b1, {(ENTRY_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } count_e;

  count_e                count_q, count_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [ENTRY_SIZE-1:0] buf_q [BUF_DEPTH];
  logic [ENTRY_SIZE-1:0] buf_d [BUF_DEPTH];
  logic [31:0]           disp_cnt_q, disp_cnt_d;

  logic                  flush_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic [ENTRY_SIZE-1:0] cand_s;
  logic                  cand_valid_s;
  logic                  from_buf_s;
  logic                  is_mem_s;
  logic                  tgt_full_s;
  logic                  dispatch_s;
  logic                  buf_disp_s;
  logic                  store_s;

  // Flush, acceptance and candidate selection.
  always_comb begin
    flush_s      = mispredict | flush_fCOM;
    in_ready_s   = (count_q != TWO) && !FREEZE;
    accept_s     = in_valid && in_ready_s && !flush_s;
    cand_s       = '0;
    cand_valid_s = 1'b0;
    from_buf_s   = 1'b0;
    if (count_q != EMPTY) begin
      cand_s       = buf_q[head_q];
      cand_valid_s = 1'b1;
      from_buf_s   = 1'b1;
    end else begin
`ifdef DISPATCH_BYPASS_EN
      cand_s       = in_entry;
      cand_valid_s = in_valid;
`else
      cand_s       = '0;
      cand_valid_s = 1'b0;
`endif
    end
  end

  // Routing and the dispatch decision; nothing issues while reset is held.
  always_comb begin
    is_mem_s   = cand_s[LD_BIT] | cand_s[ST_BIT];
    tgt_full_s = is_mem_s ? full_ls : full_alu;
    dispatch_s = cand_valid_s && !tgt_full_s && !FREEZE && !flush_s && RESET;
    buf_disp_s = dispatch_s && from_buf_s;
    // A bypassed entry leaves in its arrival cycle and is never written to the buffer.
    store_s    = accept_s && !(dispatch_s && !from_buf_s);
  end

  // Issue-queue write strobes, payload and busy-bit clear.
  always_comb begin
    do_write_alu    = 1'b0;
    do_write_ls     = 1'b0;
    write_data      = '0;
    do_clear_2BB    = 1'b0;
    clear_index_2BB = 6'd0;
    if (dispatch_s) begin
      do_write_alu = !is_mem_s;
      do_write_ls  = is_mem_s;
      write_data   = cand_s | FORCE_MASK;
      do_clear_2BB = cand_s[WB_BIT];
      if (cand_s[WB_BIT]) begin
        clear_index_2BB = cand_s[DEST_HI:DEST_LO];
      end else begin
        clear_index_2BB = 6'd0;
      end
    end else begin
      do_write_alu = 1'b0;
      do_write_ls  = 1'b0;
    end
  end

  // Buffer, pointer, occupancy and dispatch-counter next state.
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    buf_d      = buf_q;
    disp_cnt_d = disp_cnt_q;
    if (flush_s) begin
      count_d = EMPTY;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (store_s) begin
        buf_d[tail_q] = in_entry;
        tail_d        = tail_q + 1'b1;
      end else begin
        tail_d = tail_q;
      end
      if (buf_disp_s) begin
        head_d = head_q + 1'b1;
      end else begin
        head_d = head_q;
      end
      case ({store_s, buf_disp_s})
        2'b10:   count_d = count_e'(count_q + 2'd1);
        2'b01:   count_d = count_e'(count_q - 2'd1);
        default: count_d = count_q;
      endcase
    end
    if (dispatch_s) begin
      disp_cnt_d = disp_cnt_q + 32'd1;
    end else begin
      disp_cnt_d = disp_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q    <= EMPTY;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      disp_cnt_q <= 32'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      disp_cnt_q <= disp_cnt_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign in_ready       = in_ready_s;
  assign dispatch_count = disp_cnt_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl; expectations follow the build's DISPATCH_BYPASS_EN setting.
module tb_dispatch_ctrl;

  logic         CLK;
  logic         RESET;
  logic         FREEZE;
  logic         mispredict;
  logic         flush_fCOM;
  logic         in_valid;
  logic [191:0] in_entry;
  logic         in_ready;
  logic         full_alu;
  logic         full_ls;
  logic         do_write_alu;
  logic         do_write_ls;
  logic [191:0] write_data;
  logic         do_clear_2BB;
  logic [5:0]   clear_index_2BB;
  logic [31:0]  dispatch_count;

  int vectors = 0;
  int miscompares = 0;

`ifdef DISPATCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  dispatch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .mispredict(mispredict),
    .flush_fCOM(flush_fCOM), .in_valid(in_valid), .in_entry(in_entry),
    .in_ready(in_ready), .full_alu(full_alu), .full_ls(full_ls),
    .do_write_alu(do_write_alu), .do_write_ls(do_write_ls), .write_data(write_data),
    .do_clear_2BB(do_clear_2BB), .clear_index_2BB(clear_index_2BB),
    .dispatch_count(dispatch_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [191:0] mk(input logic ld, input logic st, input logic wb,
                                      input logic [5:0] dest, input logic [7:0] tag);
    logic [191:0] e;
    e          = '0;
    e[7:0]     = tag;
    e[100:93]  = ~tag;
    e[190]     = tag[0];
    e[179:174] = dest;
    e[140]     = wb;
    e[133]     = ld;
    e[135]     = st;
    return e;
  endfunction

  function automatic logic [200:0] exp_out(input logic en, input logic alu, input logic ls,
                                           input logic clr, input logic [5:0] idx,
                                           input logic [191:0] e);
    logic [191:0] wd;
    wd = e;
    wd[191] = 1'b1;
    return en ? {alu, ls, clr, idx, wd} : 201'd0;
  endfunction

  logic [200:0] obs;
  logic [200:0] expv;
  logic [191:0] e1, e2, e3;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic sample;
    obs = {do_write_alu, do_write_ls, do_clear_2BB, clear_index_2BB, write_data};
  endtask

  task automatic test_reset;
    RESET = 1'b0; FREEZE = 1'b0; mispredict = 1'b0; flush_fCOM = 1'b0;
    in_valid = 1'b0; in_entry = '0; full_alu = 1'b0; full_ls = 1'b0;
    #2;
    sample();
    vectors++;
    if (obs !== 201'd0) begin
      miscompares++; $display("FAIL reset_outs got %h want 0", obs);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    vectors++;
    if (dispatch_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_count got %0d want 0", dispatch_count);
    end
    #1 RESET = 1'b1;
    tick();
  endtask

  task automatic test_alu;
    e1 = mk(1'b0, 1'b0, 1'b1, 6'd17, 8'h11);
    in_valid = 1'b1; in_entry = e1;
    #1 sample();
    expv = exp_out(BYP, 1'b1, 1'b0, 1'b1, 6'd17, e1);
    vectors++;
    if (obs !== expv) begin
      miscompares++; $display("FAIL alu_c0 got %h want %h", obs, expv);
    end
    tick();
    in_valid = 1'b0; in_entry = '0;
    #1 sample();
    expv = exp_out(!BYP, 1'b1, 1'b0, 1'b1, 6'd17, e1);
    vectors++;
    if (obs !== expv) begin
      miscompares++; $display("FAIL alu_c1 got %h want %h", obs, expv);
    end
    tick();
    sample();
    vectors++;
    if ({obs, dispatch_count} !== {201'd0, 32'd1}) begin
      miscompares++; $display("FAIL alu_idle got %h cnt %0d want 0 cnt 1", obs, dispatch_count);
    end
  endtask

  task automatic test_ls_block;
    e1 = mk(1'b1, 1'b0, 1'b1, 6'd40, 8'h40);
    e2 = mk(1'b0, 1'b0, 1'b1, 6'd5, 8'h05);
    e3 = mk(1'b0, 1'b0, 1'b1, 6'd7, 8'h07);
    full_ls = 1'b1; full_alu = 1'b0;
    in_valid = 1'b1; in_entry = e1;
    for (int c = 0; c < 3; c++) begin
      #1 sample();
      vectors++;
      if ({obs, in_ready} !== {201'd0, 1'b1}) begin
        miscompares++; $display("FAIL ls_blocked_c%0d got %h rdy %b want 0 rdy 1", c, obs, in_ready);
      end
      tick();
      in_valid = 1'b0;
    end
    in_valid = 1'b1; in_entry = e2;
    #1 sample();
    vectors++;
    if ({obs, in_ready} !== {201'd0, 1'b1}) begin
      miscompares++; $display("FAIL ls_head_blocks_alu got %h rdy %b want 0 rdy 1", obs, in_ready);
    end
    tick();
    in_entry = e3;
    #1 sample();
    vectors++;
    if ({obs, in_ready} !== {201'd0, 1'b0}) begin
      miscompares++; $display("FAIL ls_two_full got %h rdy %b want 0 rdy 0", obs, in_ready);
    end
    full_ls = 1'b0;
    #1 sample();
    expv = exp_out(1'b1, 1'b0, 1'b1, 1'b1, 6'd40, e1);
    vectors++;
    if ({obs, in_ready} !== {expv, 1'b0}) begin
      miscompares++; $display("FAIL ls_release got %h rdy %b want %h rdy 0", obs, in_ready, expv);
    end
    tick();
    in_valid = 1'b0; in_entry = '0;
    #1 sample();
    expv = exp_out(1'b1, 1'b1, 1'b0, 1'b1, 6'd5, e2);
    vectors++;
    if (obs !== expv) begin
      miscompares++; $display("FAIL ls_then_alu got %h want %h", obs, expv);
    end
    tick();
    sample();
    vectors++;
    if ({obs, in_ready, dispatch_count} !== {201'd0, 1'b1, 32'd3}) begin
      miscompares++; $display("FAIL ls_drained got %h rdy %b cnt %0d want 0 rdy 1 cnt 3", obs, in_ready, dispatch_count);
    end
  endtask

  task automatic test_store;
    e1 = mk(1'b0, 1'b1, 1'b0, 6'd33, 8'h33);
    in_valid = 1'b1; in_entry = e1;
    #1 sample();
    expv = exp_out(BYP, 1'b0, 1'b1, 1'b0, 6'd0, e1);
    vectors++;
    if (obs !== expv) begin
      miscompares++; $display("FAIL store_c0 got %h want %h", obs, expv);
    end
    tick();
    in_valid = 1'b0; in_entry = '0;
    #1 sample();
    expv = exp_out(!BYP, 1'b0, 1'b1, 1'b0, 6'd0, e1);
    vectors++;
    if (obs !== expv) begin
      miscompares++; $display("FAIL store_c1 got %h want %h", obs, expv);
    end
    tick();
    vectors++;
    if (dispatch_count !== 32'd4) begin
      miscompares++; $display("FAIL store_count got %0d want 4", dispatch_count);
    end
  endtask

  task automatic test_flush;
    full_alu = 1'b1;
    in_valid = 1'b1; in_entry = mk(1'b0, 1'b0, 1'b1, 6'd3, 8'h44);
    tick();
    in_entry = mk(1'b0, 1'b0, 1'b1, 6'd4, 8'h55);
    tick();
    mispredict = 1'b1; full_alu = 1'b0;
    in_entry = mk(1'b0, 1'b0, 1'b1, 6'd6, 8'h66);
    #1 sample();
    vectors++;
    if ({obs, in_ready} !== {201'd0, 1'b0}) begin
      miscompares++; $display("FAIL flush_cycle got %h rdy %b want 0 rdy 0", obs, in_ready);
    end
    tick();
    mispredict = 1'b0; in_valid = 1'b0; in_entry = '0;
    #1 sample();
    vectors++;
    if ({obs, in_ready} !== {201'd0, 1'b1}) begin
      miscompares++; $display("FAIL flush_after got %h rdy %b want 0 rdy 1", obs, in_ready);
    end
    tick();
    full_alu = 1'b1;
    in_valid = 1'b1; in_entry = mk(1'b0, 1'b0, 1'b1, 6'd8, 8'h77);
    tick();
    in_valid = 1'b0; in_entry = '0;
    flush_fCOM = 1'b1; full_alu = 1'b0;
    #1 sample();
    vectors++;
    if (obs !== 201'd0) begin
      miscompares++; $display("FAIL fcom_cycle got %h want 0", obs);
    end
    tick();
    flush_fCOM = 1'b0;
    #1 sample();
    vectors++;
    if ({obs, in_ready, dispatch_count} !== {201'd0, 1'b1, 32'd4}) begin
      miscompares++; $display("FAIL fcom_after got %h rdy %b cnt %0d want 0 rdy 1 cnt 4", obs, in_ready, dispatch_count);
    end
    tick();
  endtask

  task automatic test_freeze;
    e1 = mk(1'b0, 1'b0, 1'b1, 6'd9, 8'h88);
    full_alu = 1'b1;
    in_valid = 1'b1; in_entry = e1;
    tick();
    in_entry = mk(1'b0, 1'b0, 1'b1, 6'd10, 8'h99);
    full_alu = 1'b0; FREEZE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1 sample();
      vectors++;
      if ({obs, in_ready} !== {201'd0, 1'b0}) begin
        miscompares++; $display("FAIL freeze_c%0d got %h rdy %b want 0 rdy 0", c, obs, in_ready);
      end
      tick();
    end
    FREEZE = 1'b0; in_valid = 1'b0; in_entry = '0;
    #1 sample();
    expv = exp_out(1'b1, 1'b1, 1'b0, 1'b1, 6'd9, e1);
    vectors++;
    if ({obs, in_ready} !== {expv, 1'b1}) begin
      miscompares++; $display("FAIL freeze_release got %h rdy %b want %h rdy 1", obs, in_ready, expv);
    end
    tick();
    sample();
    vectors++;
    if ({obs, dispatch_count} !== {201'd0, 32'd5}) begin
      miscompares++; $display("FAIL freeze_drained got %h cnt %0d want 0 cnt 5", obs, dispatch_count);
    end
  endtask

  task automatic test_reset_mid;
    full_alu = 1'b1;
    in_valid = 1'b1; in_entry = mk(1'b0, 1'b0, 1'b1, 6'd11, 8'hAA);
    tick();
    in_entry = mk(1'b0, 1'b0, 1'b1, 6'd12, 8'hBB);
    tick();
    in_valid = 1'b0; in_entry = '0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_two rdy %b want 0", in_ready);
    end
    full_alu = 1'b0; RESET = 1'b0;
    #1 sample();
    vectors++;
    if ({obs, in_ready, dispatch_count} !== {201'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL rst_mid_hold got %h rdy %b cnt %0d want 0 rdy 1 cnt 0", obs, in_ready, dispatch_count);
    end
    #2 RESET = 1'b1;
    tick();
    sample();
    vectors++;
    if ({obs, in_ready, dispatch_count} !== {201'd0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL rst_mid_release got %h rdy %b cnt %0d want 0 rdy 1 cnt 0", obs, in_ready, dispatch_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ls_block();
    test_store();
    test_flush();
    test_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
